// File: rtl/svmii_pkg.sv
// Shared state type and byte/CRC constants for the GMII transmit path.
package svmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAD   = 3'd3,
        ST_FCS   = 3'd4,
        ST_DRAIN = 3'd5,
        ST_IFG   = 3'd6
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected Ethernet CRC-32 for one input byte.
module crc32_d8
    import svmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, zero padding, CRC-32 FCS, inter-frame gap
// and underrun signalling in front of a valid/ready payload byte stream.
module gmii_tx_framer
    import svmii_pkg::*;
#(
    parameter int N_PREAMBLE = 8,
    parameter int N_IFG      = 12,
    parameter int MIN_FRAME  = 64,
    parameter bit PAD_EN     = 1'b1,
    parameter bit FCS_EN     = 1'b1
) (
    input  logic        gmii_gtx_clk,
    input  logic        sys_rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        gmii_en,
    output logic        gmii_er,
    output logic [7:0]  gmii_dout,
    output logic        busy,
    output logic [31:0] frame_cnt,
    output logic [15:0] underrun_cnt
);

    // state | meaning
    // IDLE  | waiting for s_valid, head byte left in place
    // PRE   | preamble bytes, SFD on the last one
    // DATA  | forwarding payload, CRC running
    // PAD   | zero fill up to MIN_FRAME-4 payload bytes
    // FCS   | complemented CRC, LS byte first
    // DRAIN | after an underrun, discarding through s_last
    // IFG   | enforced idle gap

    localparam logic [7:0]  PRE_LAST = 8'(N_PREAMBLE - 1);
    localparam logic [15:0] IFG_LAST = 16'(N_IFG - 1);
    localparam logic [16:0] PAY_MIN  = 17'(MIN_FRAME - 4);

    tx_state_t   state, state_nxt;
    logic [7:0]  pre_cnt;
    logic [15:0] byte_cnt;
    logic [15:0] ifg_cnt;
    logic [1:0]  fcs_cnt;
    logic [31:0] crc, crc_nxt, crc_inv;
    logic [7:0]  crc_din;
    logic [16:0] cnt_p1;

    assign s_ready = (state == ST_DATA) || (state == ST_DRAIN);
    assign crc_din = (state == ST_PAD) ? 8'h00 : s_data;
    assign crc_inv = ~crc;
    assign cnt_p1  = {1'b0, byte_cnt} + 17'd1;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (crc_din),
        .crc_out (crc_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (s_valid) state_nxt = ST_PRE;
            ST_PRE:   if (pre_cnt == PRE_LAST) state_nxt = ST_DATA;
            ST_DATA: begin
                if (!s_valid) begin
                    state_nxt = ST_DRAIN;
                end else if (s_last) begin
                    if (PAD_EN && (cnt_p1 < PAY_MIN)) state_nxt = ST_PAD;
                    else if (FCS_EN)                  state_nxt = ST_FCS;
                    else                              state_nxt = ST_IFG;
                end
            end
            ST_PAD:   if (cnt_p1 >= PAY_MIN) state_nxt = FCS_EN ? ST_FCS : ST_IFG;
            ST_FCS:   if (fcs_cnt == 2'd3) state_nxt = ST_IFG;
            ST_DRAIN: if (s_valid && s_last) state_nxt = ST_IFG;
            ST_IFG:   if (ifg_cnt == IFG_LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge gmii_gtx_clk) begin
        if (sys_rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            gmii_en      <= 1'b0;
            gmii_er      <= 1'b0;
            gmii_dout    <= 8'h00;
            crc          <= CRC32_INIT;
            pre_cnt      <= 8'd0;
            byte_cnt     <= 16'd0;
            ifg_cnt      <= 16'd0;
            fcs_cnt      <= 2'd0;
            frame_cnt    <= 32'd0;
            underrun_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != ST_IDLE);
            gmii_en   <= 1'b0;
            gmii_er   <= 1'b0;
            gmii_dout <= 8'h00;
            ifg_cnt   <= (state == ST_IFG) ? ifg_cnt + 16'd1 : 16'd0;
            fcs_cnt   <= (state == ST_FCS) ? fcs_cnt + 2'd1 : 2'd0;

            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        crc      <= CRC32_INIT;
                        pre_cnt  <= 8'd0;
                        byte_cnt <= 16'd0;
                    end
                end
                ST_PRE: begin
                    gmii_en   <= 1'b1;
                    gmii_dout <= (pre_cnt == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
                    pre_cnt   <= pre_cnt + 8'd1;
                end
                ST_DATA: begin
                    gmii_en <= 1'b1;
                    if (s_valid) begin
                        gmii_dout <= s_data;
                        crc       <= crc_nxt;
                        if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
                    end else begin
                        // starved mid-frame: poison the frame on the wire
                        gmii_er <= 1'b1;
                        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
                    end
                end
                ST_PAD: begin
                    gmii_en <= 1'b1;
                    crc     <= crc_nxt;
                    if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
                end
                ST_FCS: begin
                    gmii_en   <= 1'b1;
                    gmii_dout <= crc_inv[{fcs_cnt, 3'b000} +: 8];
                end
                default: ;
            endcase

            if ((state_nxt == ST_IFG) &&
                ((state == ST_DATA) || (state == ST_PAD) || (state == ST_FCS))) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: three parameterisations share one stimulus bus; wire
// bytes are compared against a byte-level frame model built from payload, padding and CRC.
module tb_gmii_tx_framer;

    localparam int MIN_FRAME = 64;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic        sys_rst, s_valid, s_last;
    logic [7:0]  s_data;
    logic [1:0]  sel;
    logic [2:0]  s_valid_v, s_ready_v, en_v, er_v, busy_v;
    logic [7:0]  dout_v [3];
    logic [31:0] fcnt_v [3];
    logic [15:0] ucnt_v [3];

    logic        s_ready_m, en_m, er_m, busy_m;
    logic [7:0]  dout_m;
    logic [31:0] fcnt_m;
    logic [15:0] ucnt_m;

    assign s_valid_v = s_valid ? (3'b001 << sel) : 3'b000;

    always_comb begin
        s_ready_m = s_ready_v[0];
        en_m      = en_v[0];
        er_m      = er_v[0];
        busy_m    = busy_v[0];
        dout_m    = dout_v[0];
        fcnt_m    = fcnt_v[0];
        ucnt_m    = ucnt_v[0];
        case (sel)
            2'd1: begin
                s_ready_m = s_ready_v[1]; en_m = en_v[1]; er_m = er_v[1]; busy_m = busy_v[1];
                dout_m = dout_v[1]; fcnt_m = fcnt_v[1]; ucnt_m = ucnt_v[1];
            end
            2'd2: begin
                s_ready_m = s_ready_v[2]; en_m = en_v[2]; er_m = er_v[2]; busy_m = busy_v[2];
                dout_m = dout_v[2]; fcnt_m = fcnt_v[2]; ucnt_m = ucnt_v[2];
            end
            default: ;
        endcase
    end

    gmii_tx_framer dut0 (
        .gmii_gtx_clk(clk), .sys_rst(sys_rst), .s_data(s_data), .s_valid(s_valid_v[0]),
        .s_last(s_last), .s_ready(s_ready_v[0]), .gmii_en(en_v[0]), .gmii_er(er_v[0]),
        .gmii_dout(dout_v[0]), .busy(busy_v[0]), .frame_cnt(fcnt_v[0]), .underrun_cnt(ucnt_v[0])
    );

    gmii_tx_framer #(.PAD_EN(1'b0)) dut1 (
        .gmii_gtx_clk(clk), .sys_rst(sys_rst), .s_data(s_data), .s_valid(s_valid_v[1]),
        .s_last(s_last), .s_ready(s_ready_v[1]), .gmii_en(en_v[1]), .gmii_er(er_v[1]),
        .gmii_dout(dout_v[1]), .busy(busy_v[1]), .frame_cnt(fcnt_v[1]), .underrun_cnt(ucnt_v[1])
    );

    gmii_tx_framer #(.N_PREAMBLE(2), .N_IFG(1), .PAD_EN(1'b0), .FCS_EN(1'b0)) dut2 (
        .gmii_gtx_clk(clk), .sys_rst(sys_rst), .s_data(s_data), .s_valid(s_valid_v[2]),
        .s_last(s_last), .s_ready(s_ready_v[2]), .gmii_en(en_v[2]), .gmii_er(er_v[2]),
        .gmii_dout(dout_v[2]), .busy(busy_v[2]), .frame_cnt(fcnt_v[2]), .underrun_cnt(ucnt_v[2])
    );

    function automatic int npre_of(input int s); return (s == 2) ? 2 : 8;  endfunction
    function automatic int nifg_of(input int s); return (s == 2) ? 1 : 12; endfunction
    function automatic bit pad_of(input int s);  return (s == 0);          endfunction
    function automatic bit fcs_of(input int s);  return (s != 2);          endfunction

    int n_pass = 0, n_fail = 0, n_total = 0;
    int cyc = 0, first_cyc = 0, start_cyc = 0;
    int run_len = 0, idle_run = 0;
    bit prev_en = 1'b0;
    int exp_fc [3] = '{0, 0, 0};
    logic [7:0] pl_q[$], exp_q[$], log_q[$];
    logic       er_q[$];
    int         len_q[$], gap_q[$];
    logic [8:0] tx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // wire monitor: one length entry per gmii_en run, one gap entry per run start
    always @(negedge clk) begin
        if (en_m === 1'b1) begin
            if (!prev_en) begin
                gap_q.push_back(idle_run);
                start_cyc = cyc;
            end
            log_q.push_back(dout_m);
            er_q.push_back(er_m);
            run_len++;
            prev_en = 1'b1;
        end else begin
            if (prev_en) begin
                len_q.push_back(run_len);
                run_len  = 0;
                idle_run = 0;
            end
            idle_run++;
            prev_en = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc32_of(input logic [7:0] d[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c = c ^ {24'h000000, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic rand_payload(input int len);
        pl_q.delete();
        for (int k = 0; k < len; k++) pl_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic load_tx();
        for (int k = 0; k < pl_q.size(); k++) tx_q.push_back({(k == pl_q.size() - 1), pl_q[k]});
    endtask

    task automatic build_exp(input int s);
        logic [7:0]  body[$];
        logic [31:0] c;
        body = pl_q;
        if (pad_of(s)) while (body.size() < MIN_FRAME - 4) body.push_back(8'h00);
        exp_q.delete();
        for (int k = 0; k < npre_of(s) - 1; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body[k]) exp_q.push_back(body[k]);
        if (fcs_of(s)) begin
            c = crc32_of(body);
            for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
        end
    endtask

    task automatic drive(input int gap_at, input int rst_at);
        int   i = 0, guard = 0;
        bit   gapped = 1'b0;
        logic rdy;
        while (i < tx_q.size() && guard < 4000) begin
            @(negedge clk);
            if (guard == 0) first_cyc = cyc;
            rdy = s_ready_m;
            if (rdy && i == gap_at && !gapped) begin
                s_valid = 1'b0;
                gapped  = 1'b1;
            end else begin
                s_valid = 1'b1;
                {s_last, s_data} = tx_q[i];
            end
            if (rdy && i == rst_at) sys_rst = 1'b1;
            @(posedge clk);
            guard++;
            if (sys_rst) break;
            if (rdy && s_valid) i++;
        end
        chk("drive handshake budget", (guard < 4000), 1);
        tx_q.delete();
        if (!sys_rst) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((busy_m || en_m) && g < 3000);
        chk({tag, " idle budget"}, (g < 3000), 1);
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int plen, input int s);
        int n, want, ers;
        logic [7:0] b;
        logic e;
        chk({tag, " frame seen"}, (len_q.size() > 0), 1);
        if (len_q.size() == 0) return;
        n    = len_q.pop_front();
        want = npre_of(s) + ((pad_of(s) && plen < MIN_FRAME - 4) ? MIN_FRAME - 4 : plen)
               + (fcs_of(s) ? 4 : 0);
        chk({tag, " en length"}, n, want);
        ers = 0;
        for (int k = 0; k < n; k++) begin
            b = log_q.pop_front();
            e = er_q.pop_front();
            if (e) ers++;
            if (k < exp_q.size()) chk($sformatf("%s byte %0d", tag, k), b, exp_q[k]);
        end
        chk({tag, " er cycles"}, ers, 0);
    endtask

    task automatic good_frame(input string tag, input int s, input int len);
        sel = 2'(s);
        rand_payload(len);
        build_exp(s);
        load_tx();
        drive(-1, -1);
        wait_idle(tag);
        check_frame(tag, len, s);
        exp_fc[s]++;
        chk({tag, " frame_cnt"}, fcnt_m, exp_fc[s]);
    endtask

    initial begin
        #400000;
        $display("FAIL global timeout: %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [7:0] exp1[$], exp2[$];
        string vec;
        int n, ers;
        logic [7:0] b;
        logic e;

        sys_rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset gmii_en", en_m, 0);
        chk("reset gmii_er", er_m, 0);
        chk("reset gmii_dout", dout_m, 8'h00);
        chk("reset busy", busy_m, 0);
        chk("reset s_ready", s_ready_m, 0);
        chk("reset frame_cnt", fcnt_m, 0);
        chk("reset underrun_cnt", ucnt_m, 0);
        @(negedge clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);

        // CRC check vector on the unpadded instance, expectations written out literally
        sel = 2'd1;
        vec = "123456789";
        pl_q.delete();
        for (int k = 0; k < vec.len(); k++) pl_q.push_back(vec[k]);
        exp_q.delete();
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (pl_q[k]) exp_q.push_back(pl_q[k]);
        exp_q.push_back(8'h26); exp_q.push_back(8'h39);
        exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        load_tx();
        drive(-1, -1);
        wait_idle("fcs_vec");
        check_frame("fcs_vec", 9, 1);
        exp_fc[1]++;
        chk("fcs_vec frame_cnt", fcnt_m, exp_fc[1]);

        // single byte padded to minimum length, plus start latency
        sel = 2'd0;
        pl_q.delete();
        pl_q.push_back(8'hAA);
        build_exp(0);
        load_tx();
        drive(-1, -1);
        chk("start latency", start_cyc - first_cyc, 2);
        wait_idle("pad1");
        check_frame("pad1", 1, 0);
        exp_fc[0]++;
        chk("pad1 frame_cnt", fcnt_m, exp_fc[0]);

        good_frame("len59", 0, 59);
        good_frame("len60", 0, 60);
        good_frame("len61", 0, 61);
        good_frame("short_rand", 0, $urandom_range(2, 58));
        good_frame("long_rand", 0, $urandom_range(62, 140));
        good_frame("nopad_rand", 1, $urandom_range(1, 40));

        // back-to-back 60-byte frames with s_valid held high
        sel = 2'd0;
        gap_q.delete();
        rand_payload(60); build_exp(0); exp1 = exp_q; load_tx();
        rand_payload(60); build_exp(0); exp2 = exp_q; load_tx();
        drive(-1, -1);
        wait_idle("b2b");
        exp_q = exp1; check_frame("b2b first", 60, 0);
        exp_q = exp2; check_frame("b2b second", 60, 0);
        chk("b2b gap", (gap_q.size() > 0) ? gap_q[gap_q.size() - 1] : -1, nifg_of(0) + 1);
        exp_fc[0] += 2;
        chk("b2b frame_cnt", fcnt_m, exp_fc[0]);

        // underrun after 10 payload bytes
        rand_payload(30); build_exp(0); load_tx();
        drive(10, -1);
        wait_idle("underrun");
        chk("underrun frame seen", (len_q.size() > 0), 1);
        if (len_q.size() > 0) begin
            n = len_q.pop_front();
            chk("underrun en length", n, npre_of(0) + 11);
            ers = 0;
            for (int k = 0; k < n; k++) begin
                b = log_q.pop_front();
                e = er_q.pop_front();
                if (k == npre_of(0) + 10) begin
                    chk("underrun er byte", b, 8'h00);
                    chk("underrun er flag", e, 1);
                end else begin
                    if (e) ers++;
                    chk($sformatf("underrun byte %0d", k), b, exp_q[k]);
                end
            end
            chk("underrun stray er", ers, 0);
        end
        chk("underrun no further en", len_q.size(), 0);
        chk("underrun_cnt", ucnt_m, 1);
        chk("underrun frame_cnt", fcnt_m, exp_fc[0]);

        // reset while payload byte 20 is offered
        rand_payload(40); load_tx();
        drive(-1, 19);
        #1;
        chk("midrst gmii_en", en_m, 0);
        chk("midrst gmii_er", er_m, 0);
        chk("midrst gmii_dout", dout_m, 8'h00);
        chk("midrst busy", busy_m, 0);
        chk("midrst s_ready", s_ready_m, 0);
        chk("midrst frame_cnt", fcnt_m, 0);
        chk("midrst underrun_cnt", ucnt_m, 0);
        @(negedge clk);
        sys_rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst truncated seen", (len_q.size() > 0), 1);
        if (len_q.size() > 0) begin
            n = len_q.pop_front();
            chk("midrst truncated length", n, npre_of(0) + 19);
            for (int k = 0; k < n; k++) begin
                b = log_q.pop_front();
                e = er_q.pop_front();
            end
        end
        exp_fc = '{0, 0, 0};
        good_frame("after_rst", 0, 45);

        // minimal parameter set, two 3-byte frames back to back
        sel = 2'd2;
        gap_q.delete();
        rand_payload(3); build_exp(2); exp1 = exp_q; load_tx();
        rand_payload(3); build_exp(2); exp2 = exp_q; load_tx();
        drive(-1, -1);
        wait_idle("sweep");
        exp_q = exp1; check_frame("sweep first", 3, 2);
        exp_q = exp2; check_frame("sweep second", 3, 2);
        chk("sweep gap", (gap_q.size() > 0) ? gap_q[gap_q.size() - 1] : -1, nifg_of(2) + 1);
        exp_fc[2] += 2;
        chk("sweep frame_cnt", fcnt_m, exp_fc[2]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gmii_tx_framer.md
# gmii_tx_framer

Synthesisable GMII transmit framer: takes frame payload bytes from a valid/ready byte stream and drives a GMII transmitter. It generates preamble/SFD, optional zero-padding to minimum frame length, optional FCS (CRC-32) append, enforced inter-frame gap and underrun signalling. It sits between the TAP-side frame FIFO and the GMII pins of `hub`, and replaces bench-side preamble/IFG generation with a parametrised hardware block.

## Interface
- `N_PREAMBLE`, 8: wire bytes before payload, including SFD (min 2).
- `N_IFG`, 12: minimum idle cycles (`gmii_en`=0) after each frame (min 1).
- `MIN_FRAME`, 64: minimum frame length including FCS, used by padding.
- `PAD_EN`, 1: pad short payloads with 0x00 up to `MIN_FRAME`-4 bytes.
- `FCS_EN`, 1: append 4-byte CRC-32 FCS.
- `gmii_gtx_clk`  in  1  125 MHz clock; all logic on rising edge.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `s_data`  in  8  payload byte (destination MAC first).
- `s_valid`  in  1  `s_data` valid.
- `s_last`  in  1  final payload byte of frame.
- `s_ready`  out  1  byte accepted when `s_valid && s_ready`.
- `gmii_en`  out  1  GMII TX_EN.
- `gmii_er`  out  1  GMII TX_ER.
- `gmii_dout`  out  8  GMII TXD.
- `busy`  out  1  state != IDLE.
- `frame_cnt`  out  32  completed frames, wraps at 2^32.
- `underrun_cnt`  out  16  aborted frames, saturates at 0xFFFF.

## Operation
- States: IDLE, PRE, DATA, PAD, FCS, DRAIN, IFG.
- IDLE: `s_ready`=0; on `s_valid`=1, go to PRE. The head byte is not consumed.
- PRE: emit `N_PREAMBLE`-1 bytes of 0x55, then 0xD5. Go to DATA on the same edge that registers 0xD5.
- DATA: `s_ready`=1. Each accepted byte is emitted, fed to the CRC and counted in `byte_cnt` (16 bit, saturating).
  - Accepted `s_last`: go to PAD if `PAD_EN` and `byte_cnt`+1 < `MIN_FRAME`-4; else go to FCS if `FCS_EN`; else go to IFG.
- PAD: emit 0x00 (CRC'd) until the payload plus pad reaches `MIN_FRAME`-4 bytes. Then go to FCS, or to IFG if `FCS_EN`=0.
- FCS: emit the complemented CRC LS byte first over 4 cycles. Go to IFG.
- Underrun: in DATA with `s_valid`=0 emit one cycle of `gmii_en`=1, `gmii_er`=1, `gmii_dout`=0x00, then increment `underrun_cnt`.
  - Then go to DRAIN, or straight to IFG if `s_last` has already been seen (cannot happen in DATA).
- DRAIN: `s_ready`=1. Discard bytes until `s_last` is accepted, then go to IFG. `gmii_en`=0 throughout.
- IFG: `gmii_en`=0 for exactly `N_IFG` cycles, then go to IDLE. `frame_cnt` increments on IFG entry from FCS/PAD/DATA, not from DRAIN.
- CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, reset at PRE entry, final XOR 0xFFFFFFFF.
- Oversize payloads are transmitted unmodified; no truncation.

## Timing
- All GMII outputs and `busy` are registered.
- `s_ready` is combinational from the state register only; it never depends on `s_valid`.
- Reset values:
  - `gmii_en`, `gmii_er`, `busy`, `s_ready` = 0.
  - `gmii_dout` = 0x00.
  - Both counters = 0.
  - state = IDLE, CRC = 0xFFFFFFFF.
- Latency:
  - `s_valid` rises in IDLE at edge t → first 0x55 appears after edge t+1.
  - A byte accepted at edge k appears on `gmii_dout` after edge k; payload follows SFD with no gap.
- Frame length on the wire: `N_PREAMBLE` + max(payload, `MIN_FRAME`-4 if `PAD_EN`) + 4·`FCS_EN` cycles of `gmii_en`=1.
- Back-to-back frames: gap between frames is exactly `N_IFG` cycles plus 1 IDLE cycle.
- Reset mid-frame: outputs take reset values on the next edge. No IFG or FCS is emitted and the input is not drained. Upstream must flush its own frame.
- `s_valid` may drop in IFG/IDLE without effect. `s_last` outside DATA/DRAIN is ignored.

## Structure
- Package `svmii_pkg`:
  - state enum `tx_state_t`.
  - constants `PREAMBLE_BYTE`=0x55, `SFD_BYTE`=0xD5, `CRC32_POLY`=0xEDB88320, `CRC32_INIT`=0xFFFFFFFF.
- Sub-module `crc32_d8`: combinational next-CRC for one byte. The register lives in the framer.
- Counters and FSM stay in `gmii_tx_framer`.

## Test plan
- **FCS check vector** (`PAD_EN`=0, `FCS_EN`=1): payload ASCII "123456789" → 0x55×7, 0xD5, 9 payload bytes, then FCS bytes 0x26 0x39 0xF4 0xCB. `gmii_en` high 21 cycles.
- **Short frame padding** (defaults): 1-byte payload 0xAA → 0xAA followed by 59×0x00, then 4 FCS bytes. `gmii_en` high 72 cycles, `frame_cnt`=1.
- **Back-to-back frames**: two 60-byte frames with `s_valid` held high → exactly 12 cycles `gmii_en`=0 between them (plus 1 IDLE cycle), `frame_cnt`=2.
- **Underrun**: drop `s_valid` for 1 cycle after 10 payload bytes → one cycle `gmii_er`=1 with `gmii_dout`=0x00, then `gmii_en`=0. Remaining bytes through `s_last` are absorbed, `underrun_cnt`=1, `frame_cnt` unchanged.
- **Reset mid-frame**: assert `sys_rst` during payload byte 20 → next edge all outputs at reset values. A new frame then starts cleanly with a correct FCS.
- **Parameter sweep**: `N_PREAMBLE`=2, `N_IFG`=1, `FCS_EN`=0, `PAD_EN`=0, 3-byte payload → 0x55, 0xD5, 3 bytes, then 1 idle cycle.
